// File: rtl/ballot_session_controller.sv
// Purpose: sequences one polling session (open, authorize, vote, commit, close) for a 4-candidate ballot box.
// Latency: every output is registered; a valid vote sampled at cycle N shows cand_inc/voters_cast at N+1.
// Backpressure: none; pulses are consumed the cycle they arrive, and inputs that are not legal in the current state are ignored or rejected.
module ballot_session_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_VOTERS     = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       open_poll,
  input  logic       close_poll,
  input  logic       voter_auth,
  input  logic [3:0] vote_btn,
  output logic [3:0] cand_inc,
  output logic [1:0] poll_state,
  output logic       ballot_armed,
  output logic [7:0] voters_cast,
  output logic       reject_pulse,
  output logic       timeout_pulse,
  output logic       results_en
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_AUTH = 3'd1,
    ARMED     = 3'd2,
    COMMIT    = 3'd3,
    CLOSED    = 3'd4
  } state_t;

  localparam logic [1:0]  PS_IDLE   = 2'b00;
  localparam logic [1:0]  PS_OPEN   = 2'b01;
  localparam logic [1:0]  PS_CLOSED = 2'b10;
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MAX_CNT   = 8'(MAX_VOTERS);

  state_t      state;
  logic [15:0] tmo_cnt;   // ARMED cycles already spent without a commit
  logic        one_vote;  // exactly one candidate pressed
  logic        spoiled;   // two or more candidates pressed

  // Classify the button pattern seen this cycle.
  always_comb begin
    one_vote = $onehot(vote_btn);
    spoiled  = (vote_btn != 4'd0) && !one_vote;
  end

  // Session FSM; next-phase outputs are registered alongside the state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      cand_inc      <= 4'd0;
      poll_state    <= PS_IDLE;
      ballot_armed  <= 1'b0;
      voters_cast   <= 8'd0;
      reject_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      results_en    <= 1'b0;
      tmo_cnt       <= 16'd0;
    end else begin
      cand_inc      <= 4'd0;
      reject_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (open_poll) begin
            state      <= WAIT_AUTH;
            poll_state <= PS_OPEN;
          end
        end
        WAIT_AUTH: begin
          // No ballot is authorized, so any press is a refused attempt.
          reject_pulse <= (vote_btn != 4'd0);
          if (close_poll) begin
            state      <= CLOSED;
            poll_state <= PS_CLOSED;
            results_en <= 1'b1;
          end else if (voter_auth) begin
            state        <= ARMED;
            ballot_armed <= 1'b1;
            tmo_cnt      <= 16'd0;
          end
        end
        ARMED: begin
          reject_pulse <= spoiled;
          // Closing beats a same-cycle vote; a vote on the last cycle beats the timeout.
          if (close_poll) begin
            state        <= CLOSED;
            poll_state   <= PS_CLOSED;
            results_en   <= 1'b1;
            ballot_armed <= 1'b0;
          end else if (one_vote) begin
            state        <= COMMIT;
            ballot_armed <= 1'b0;
            cand_inc     <= vote_btn;
            voters_cast  <= voters_cast + 8'd1;
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= WAIT_AUTH;
            ballot_armed  <= 1'b0;
            timeout_pulse <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        COMMIT: begin
          // The count already includes this ballot; a full roll closes the poll.
          if (close_poll || (voters_cast == MAX_CNT)) begin
            state      <= CLOSED;
            poll_state <= PS_CLOSED;
            results_en <= 1'b1;
          end else begin
            state <= WAIT_AUTH;
          end
        end
        CLOSED: begin
          state <= CLOSED;
        end
        default: begin
          state        <= IDLE;
          poll_state   <= PS_IDLE;
          ballot_armed <= 1'b0;
          results_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ballot_session_controller.md
BALLOT_SESSION_CONTROLLER -- requirements
Module: ballot_session_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000; the number of ARMED cycles allowed before an unused ballot is cancelled (range 2..65535).
REQ-002 Parameter MAX_VOTERS, default 255; the ballot count at which the poll closes automatically (range 1..255).
REQ-003 clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 open_poll  in  1  single-cycle pulse that opens the poll.
REQ-006 close_poll  in  1  single-cycle pulse that closes the poll.
REQ-007 voter_auth  in  1  single-cycle pulse from the official; authorizes one ballot.
REQ-008 vote_btn  in  4  debounced single-cycle valid-vote pulses; bit i is candidate i+1.
REQ-009 cand_inc  out  4  one-hot single-cycle increment strobe to the vote logger.
REQ-010 poll_state  out  2  poll phase: 00 IDLE, 01 OPEN, 10 CLOSED; 11 never driven.
REQ-011 ballot_armed  out  1  high while a ballot is authorized and unused.
REQ-012 voters_cast  out  8  count of committed ballots.
REQ-013 reject_pulse  out  1  single-cycle flag for a refused vote attempt.
REQ-014 timeout_pulse  out  1  single-cycle flag for a cancelled, expired ballot.
REQ-015 results_en  out  1  high in CLOSED; drives the display result mode.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_AUTH, ARMED, COMMIT and CLOSED, and every output SHALL be registered.
REQ-017 poll_state SHALL read 01 in WAIT_AUTH, ARMED and COMMIT, 00 in IDLE and 10 in CLOSED; ballot_armed SHALL be 1 only in ARMED.
REQ-018 IDLE SHALL move to WAIT_AUTH on open_poll; all other inputs in IDLE are ignored.
REQ-019 WAIT_AUTH SHALL move to ARMED on voter_auth and clear the timeout counter.
REQ-020 In WAIT_AUTH, any nonzero vote_btn SHALL give reject_pulse=1 for one cycle and no cand_inc.
REQ-021 In ARMED, exactly one vote_btn bit set at cycle N SHALL give COMMIT at N+1, with cand_inc equal to that bit and voters_cast+1 in the same cycle.
REQ-022 COMMIT SHALL last exactly one cycle; cand_inc SHALL be zero in every other state.
REQ-023 After COMMIT the FSM SHALL go to WAIT_AUTH, or to CLOSED when the new voters_cast equals MAX_VOTERS.
REQ-024 In ARMED, two or more vote_btn bits set SHALL count as a spoiled attempt: reject_pulse=1, no commit, stay ARMED, timeout counter not cleared.
REQ-025 voter_auth in ARMED or COMMIT SHALL be ignored; authorizations never queue.
REQ-026 If ARMED persists TIMEOUT_CYCLES cycles with no commit, the next cycle SHALL be WAIT_AUTH with timeout_pulse=1.
REQ-027 A single valid vote on the last allowed ARMED cycle SHALL be committed and SHALL NOT raise timeout_pulse.
REQ-028 close_poll in WAIT_AUTH or ARMED SHALL go to CLOSED next cycle, discarding any armed ballot.
REQ-029 close_poll in the same cycle as a valid vote SHALL win: no cand_inc, no count change.
REQ-030 close_poll during COMMIT SHALL let the commit complete, then go to CLOSED.
REQ-031 CLOSED SHALL be exited only by reset; open_poll and all other inputs there are ignored, and vote_btn there gives no reject_pulse.
REQ-032 voters_cast SHALL never wrap; MAX_VOTERS auto-close guarantees this.
REQ-033 results_en SHALL equal 1 exactly when poll_state is 10.

Reset
REQ-034 With reset low at a clock edge: state IDLE, cand_inc 0, poll_state 00, ballot_armed 0, voters_cast 0, reject_pulse 0, timeout_pulse 0, results_en 0, timeout counter 0.
REQ-035 Reset SHALL take priority over every input in every state, including mid-COMMIT; an in-flight cand_inc is suppressed.

Verification
REQ-036 Reset, open_poll, voter_auth, vote_btn=0100 at cycle N -> cand_inc=0100 at N+1, voters_cast=1, WAIT_AUTH at N+2.
REQ-037 ARMED, vote_btn=0011 -> reject_pulse=1, ballot_armed stays 1; then vote_btn=0001 -> cand_inc=0001.
REQ-038 TIMEOUT_CYCLES=4, voter_auth, no votes -> timeout_pulse=1 after 4 ARMED cycles, poll_state=01; vote on the 4th ARMED cycle -> commit, no timeout.
REQ-039 MAX_VOTERS=2, two full ballots -> after the second COMMIT, poll_state=10, results_en=1; later vote_btn ignored.
REQ-040 ARMED, close_poll with vote_btn=1000 in the same cycle -> CLOSED, cand_inc stays 0, voters_cast unchanged.
REQ-041 reset low during COMMIT -> next cycle all outputs at their reset values, cand_inc=0.
